// File: rtl/hex_frame_loader.sv
// Parses ASCII hex lines from the UART RX side into a frame buffer.
// Ports: char_vld/char_data in; tx_* handshake out to MAC; frame_cnt/err_cnt stats.
module hex_frame_loader #(
  parameter int MAX_LEN = 1514,
  parameter int MIN_LEN = 60,
  parameter int AW      = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          char_vld,
  input  logic [7:0]    char_data,
  output logic          tx_vld,
  output logic [AW-1:0] tx_count,
  input  logic [AW-1:0] tx_addr,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   err_cnt
);

  localparam logic [AW-1:0] MAX_W = AW'(MAX_LEN);
  localparam logic [AW-1:0] MIN_W = AW'(MIN_LEN);

  typedef enum logic [1:0] {
    COLLECT,
    DISCARD,
    SEND,
    WAIT
  } state_t;

  state_t        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] len_q;
  logic          nib_pend_q;
  logic [3:0]    hi_q;
  logic          drop_q;

  logic [7:0] mem [0:2**AW-1];

  logic       is_hex;
  logic       is_sep;
  logic       is_eol;
  logic [3:0] nib;
  logic       we;
  logic       drop_d;
  logic       drop_err;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (char_data >= 8'h30 && char_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = char_data[3:0];
    end else if ((char_data >= 8'h61 && char_data <= 8'h66) ||
                 (char_data >= 8'h41 && char_data <= 8'h46)) begin
      // 'a'/'A' low nibble is 1, so +9 maps a..f onto 10..15
      is_hex = 1'b1;
      nib    = char_data[3:0] + 4'd9;
    end
    is_sep = (char_data == 8'h20) || (char_data == 8'h09) ||
             (char_data == 8'h3A);
    is_eol = (char_data == 8'h0D) || (char_data == 8'h0A);
  end

  assign we = char_vld && (state_q == COLLECT) && is_hex &&
              nib_pend_q && (wr_ptr_q != MAX_W);

  // Drop tracking while the MAC owns the buffer: an EOL ends the
  // dropped line, anything else marks the line as partially lost.
  assign drop_d   = char_vld ? !is_eol : drop_q;
  assign drop_err = char_vld && !is_eol && !drop_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr_q] <= {hi_q, nib};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data <= 8'h00;
    end else begin
      tx_data <= (tx_addr < len_q) ? mem[tx_addr] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= COLLECT;
      wr_ptr_q   <= '0;
      len_q      <= '0;
      nib_pend_q <= 1'b0;
      hi_q       <= 4'h0;
      drop_q     <= 1'b0;
      tx_vld     <= 1'b0;
      tx_count   <= '0;
      frame_cnt  <= 16'h0;
      err_cnt    <= 16'h0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (char_vld) begin
            if (is_hex) begin
              if (!nib_pend_q) begin
                hi_q       <= nib;
                nib_pend_q <= 1'b1;
              end else if (wr_ptr_q == MAX_W) begin
                nib_pend_q <= 1'b0;
                err_cnt    <= sat_inc(err_cnt);
                state_q    <= DISCARD;
              end else begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                nib_pend_q <= 1'b0;
              end
            end else if (is_eol) begin
              if (nib_pend_q) begin
                err_cnt    <= sat_inc(err_cnt);
                wr_ptr_q   <= '0;
                nib_pend_q <= 1'b0;
              end else if (wr_ptr_q != '0) begin
                len_q     <= wr_ptr_q;
                tx_count  <= (wr_ptr_q < MIN_W) ? MIN_W : wr_ptr_q;
                tx_vld    <= 1'b1;
                frame_cnt <= sat_inc(frame_cnt);
                state_q   <= SEND;
              end
            end else if (!is_sep) begin
              err_cnt <= sat_inc(err_cnt);
              state_q <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (char_vld && is_eol) begin
            wr_ptr_q   <= '0;
            nib_pend_q <= 1'b0;
            state_q    <= COLLECT;
          end
        end
        SEND: begin
          drop_q <= drop_d;
          if (drop_err) err_cnt <= sat_inc(err_cnt);
          if (tx_busy) begin
            tx_vld  <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (drop_err) err_cnt <= sat_inc(err_cnt);
          if (!tx_busy) begin
            wr_ptr_q   <= '0;
            nib_pend_q <= 1'b0;
            drop_q     <= 1'b0;
            state_q    <= drop_d ? DISCARD : COLLECT;
          end else begin
            drop_q <= drop_d;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_frame_loader.sv
// Scoreboard bench for hex_frame_loader: lines push expected frames,
// a MAC model pops and compares them when tx_vld appears.
module tb_hex_frame_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        char_vld;
  logic [7:0]  char_data;
  logic        tx_vld;
  logic [10:0] tx_count;
  logic [10:0] tx_addr;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  int exp_frames = 0;
  int hold = 0;

  int         exp_len[$];
  logic [7:0] exp_bytes[$];

  int         m_n;
  int         m_cnt;
  logic [7:0] m_exp;

  always #5 clk = ~clk;

  hex_frame_loader dut (
    .clk       (clk),
    .reset     (reset),
    .char_vld  (char_vld),
    .char_data (char_data),
    .tx_vld    (tx_vld),
    .tx_count  (tx_count),
    .tx_addr   (tx_addr),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n, input bit up);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (up ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    char_vld  = 1'b1;
    char_data = c;
    @(negedge clk);
    char_vld  = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit up);
    send_char(hx(b[7:4], up));
    send_char(hx(b[3:0], up));
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_bytes.push_back(b);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_len.size() != 0 || tx_busy || tx_vld) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", k < 5000, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_cnts(input string tag);
    chk({tag, "_err"}, err_cnt, exp_err);
    chk({tag, "_frames"}, frame_cnt, exp_frames);
  endtask

  // MAC model
  initial begin
    tx_busy = 1'b0;
    tx_addr = '0;
    forever begin
      @(negedge clk);
      if (tx_vld) begin
        chk("frame_expected", exp_len.size() != 0, 1);
        m_n = (exp_len.size() != 0) ? exp_len.pop_front() : 0;
        m_cnt = (m_n < 60) ? 60 : m_n;
        chk("tx_count", tx_count, m_cnt);
        exp_frames++;
        chk("frame_cnt_live", frame_cnt, exp_frames);
        tx_busy = 1'b1;
        for (int a = 0; a < m_cnt; a++) begin
          tx_addr = 11'(a);
          @(negedge clk);
          if (a == 0) chk("tx_vld_drop", tx_vld, 0);
          m_exp = 8'h00;
          if (a < m_n && exp_bytes.size() != 0) m_exp = exp_bytes.pop_front();
          chk("tx_data", tx_data, m_exp);
        end
        repeat (hold) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset     = 1'b1;
    char_vld  = 1'b0;
    char_data = 8'h00;
    repeat (4) @(negedge clk);
    chk("rst_tx_vld", tx_vld, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: mixed case, CRLF yields one frame padded to 60
    push_byte(8'h00); push_byte(8'h11); push_byte(8'hAA);
    push_byte(8'hBB); push_byte(8'hCC); push_byte(8'hDD);
    exp_len.push_back(6);
    send_str("0011aabbCCdd\r\n");
    wait_idle();
    check_cnts("t1");

    // 2: 64 bytes separated by ':'
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      b = 8'(i * 37 + 5);
      push_byte(b);
      send_byte(b, i[0]);
      if (i != 63) send_char(8'h3A);
    end
    exp_len.push_back(64);
    send_char(8'h0A);
    wait_idle();
    check_cnts("t2");

    // 3: bad char discards line, next line is sent
    send_str("12g4\n");
    exp_err++;
    push_byte(8'h55); push_byte(8'h66);
    exp_len.push_back(2);
    send_str("5566\n");
    wait_idle();
    check_cnts("t3");

    // 4: odd digit count, then a single byte frame
    send_str("123\n");
    exp_err++;
    repeat (4) @(negedge clk);
    chk("t4_no_vld", tx_vld, 0);
    push_byte(8'hAB);
    exp_len.push_back(1);
    send_str("ab\n");
    wait_idle();
    check_cnts("t4");

    // 5: overflow at 1515 bytes
    for (int i = 0; i < 1515; i++) send_byte(8'(i), 1'b0);
    send_char(8'h0A);
    exp_err++;
    repeat (4) @(negedge clk);
    chk("t5_no_vld", tx_vld, 0);
    check_cnts("t5a");
    push_byte(8'hBE); push_byte(8'hEF);
    exp_len.push_back(2);
    send_str("beef\n");
    wait_idle();
    check_cnts("t5");

    // 6: line arriving while MAC is busy is dropped
    hold = 20;
    push_byte(8'h01); push_byte(8'h02);
    exp_len.push_back(2);
    send_str("0102\n");
    k = 0;
    while (!tx_busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_busy_timeout", k < 100, 1);
    send_str("ff\n");
    exp_err++;
    wait_idle();
    check_cnts("t6a");
    hold = 0;
    push_byte(8'h03); push_byte(8'h04);
    exp_len.push_back(2);
    send_str("0304\n");
    wait_idle();
    check_cnts("t6");
    chk("sb_empty", exp_bytes.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
